// File: rtl/sensor_monitor_pkg.sv
// Shared constants, clear-FSM state type and the per-group fault rule
// for the multi-group sensor monitor.
package sensor_monitor_pkg;

    localparam int unsigned GROUP_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } clear_state_t;

    // Fault when s0 is set, or s1 together with either s2 or s3.
    function automatic logic sensor_rule(input logic [GROUP_W-1:0] s);
        return s[0] | (s[1] & s[3]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sensor_group.sv
// One sensor group: fault rule, saturating persistence counter and sticky
// qualified fault. fault_set pulses on the edge where the fault latches.
module sensor_group
    import sensor_monitor_pkg::*;
#(
    parameter int unsigned PERSIST = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [GROUP_W-1:0] s_q,
    input  logic               clear,
    output logic               fault_set,
    output logic               fault
);

    localparam int unsigned PCNT_W = $clog2(PERSIST + 1);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PERSIST);

    logic [PCNT_W-1:0] cnt_q;
    logic [PCNT_W-1:0] cnt_d;
    logic              fault_q;
    logic              fault_d;
    logic              raw;

    // A clear on the same edge as qualification wins.
    always_comb begin
        raw       = sensor_rule(s_q);
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        fault_set = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            fault_d = 1'b0;
        end else begin
            if (!raw) begin
                cnt_d = '0;
            end else if (cnt_q != PCNT_MAX) begin
                cnt_d = cnt_q + PCNT_W'(1);
            end
            if ((cnt_d == PCNT_MAX) && (cnt_q != PCNT_MAX) && !fault_q) begin
                fault_d   = 1'b1;
                fault_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule

// File: rtl/sensor_monitor.sv
// Multi-group sensor fault monitor: input register, per-group qualification,
// clear req/ack FSM and saturating fault-event counter.
// Optional per-group masking is built when SENSOR_MONITOR_MASK_EN is defined.
module sensor_monitor
    import sensor_monitor_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = 4,
    parameter int unsigned PERSIST    = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GROUP_W*NUM_GROUPS-1:0] sensors,
`ifdef SENSOR_MONITOR_MASK_EN
    input  logic [NUM_GROUPS-1:0]         group_mask,
`endif
    input  logic                          clear_req,
    output logic                          clear_ack,
    output logic [NUM_GROUPS-1:0]         raw_error,
    output logic [NUM_GROUPS-1:0]         fault,
    output logic                          any_fault,
    output logic [CNT_W-1:0]              fault_count
);

    localparam int unsigned SENS_W = GROUP_W * NUM_GROUPS;
    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

    logic [SENS_W-1:0]     sensors_q;
    logic [NUM_GROUPS-1:0] mask_q;
    logic [GROUP_W-1:0]    grp_s [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] fault_set;

    clear_state_t          state_q;
    clear_state_t          state_d;
    logic                  clear_c;
    logic                  clear_ack_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sensors_q <= '0;
            mask_q    <= '0;
        end else begin
            sensors_q <= sensors;
`ifdef SENSOR_MONITOR_MASK_EN
            mask_q    <= group_mask;
`else
            mask_q    <= '0;
`endif
        end
    end

    // A masked group sees all-zero sensors: counter held at 0, no new sets.
    always_comb begin
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            grp_s[g]     = mask_q[g] ? '0 : sensors_q[g*GROUP_W +: GROUP_W];
            raw_error[g] = sensor_rule(grp_s[g]);
        end
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        sensor_group #(
            .PERSIST (PERSIST)
        ) u_group (
            .clk       (clk),
            .rst       (rst),
            .s_q       (grp_s[g]),
            .clear     (clear_c),
            .fault_set (fault_set[g]),
            .fault     (fault[g])
        );
    end

    // Clear FSM: clear fires only on the IDLE->ACK edge, so a held request
    // does not re-clear.
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    clear_c = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!clear_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if ((|fault_set) && !clear_c && (count_q != COUNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clear_ack_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            clear_ack_q <= (state_d == ACK);
            count_q     <= count_d;
        end
    end

    assign clear_ack   = clear_ack_q;
    assign fault_count = count_q;
    assign any_fault   = |fault;

endmodule

// File: tb/tb_sensor_monitor.sv
// Scoreboard bench for sensor_monitor: directed phases plus randomized
// stimulus, checked against a streak-based behavioural model.
module tb_sensor_monitor;

    localparam int NG   = 4;
    localparam int PERS = 3;
    localparam int CW   = 3;
    localparam int SW   = 4 * NG;
    localparam logic [15:0] RULE_TBL = 16'hEEEA;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sensors;
    logic          clear_req;
    logic          clear_ack;
    logic [NG-1:0] raw_error;
    logic [NG-1:0] fault;
    logic          any_fault;
    logic [CW-1:0] fault_count;

    always #5 clk = ~clk;

    sensor_monitor #(
        .NUM_GROUPS (NG),
        .PERSIST    (PERS),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensors     (sensors),
`ifdef SENSOR_MONITOR_MASK_EN
        .group_mask  ('0),
`endif
        .clear_req   (clear_req),
        .clear_ack   (clear_ack),
        .raw_error   (raw_error),
        .fault       (fault),
        .any_fault   (any_fault),
        .fault_count (fault_count)
    );

    typedef struct {
        logic [NG-1:0] raw;
        logic [NG-1:0] flt;
        logic          any;
        logic [CW-1:0] cnt;
        logic          ack;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Behavioural model state
    logic [SW-1:0] m_sq;
    int            m_streak[NG];
    logic [NG-1:0] m_fault;
    int            m_cnt;
    bit            m_ack;

    function automatic bit rule_of(input logic [3:0] v);
        logic [15:0] t;
        t = RULE_TBL;
        return t[v];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, expv);
        end
    endtask

    // One cycle of stimulus; the model predicts the state after the next edge.
    task automatic step(input logic r, input logic [SW-1:0] s, input logic req);
        exp_t e;
        bit   clr;
        bit   rose;
        @(negedge clk);
        rst       = r;
        sensors   = s;
        clear_req = req;
        if (r) begin
            m_sq    = '0;
            m_fault = '0;
            m_cnt   = 0;
            m_ack   = 1'b0;
            for (int g = 0; g < NG; g++) m_streak[g] = 0;
        end else begin
            clr  = !m_ack && req;
            rose = 1'b0;
            for (int g = 0; g < NG; g++) begin
                if (clr) begin
                    m_streak[g] = 0;
                    m_fault[g]  = 1'b0;
                end else begin
                    m_streak[g] = rule_of(m_sq[4*g +: 4]) ? m_streak[g] + 1 : 0;
                    if (m_streak[g] >= PERS && !m_fault[g]) begin
                        m_fault[g] = 1'b1;
                        rose       = 1'b1;
                    end
                end
            end
            if (rose && m_cnt < (2 ** CW) - 1) m_cnt++;
            m_ack = req;
            m_sq  = s;
        end
        for (int g = 0; g < NG; g++) e.raw[g] = rule_of(m_sq[4*g +: 4]);
        e.flt = m_fault;
        e.any = |m_fault;
        e.cnt = CW'(m_cnt);
        e.ack = m_ack;
        exp_q.push_back(e);
    endtask

    // Monitor: compares DUT outputs just after each edge that has a prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("raw_error",   32'(raw_error),   32'(e.raw));
                chk("fault",       32'(fault),       32'(e.flt));
                chk("any_fault",   32'(any_fault),   32'(e.any));
                chk("fault_count", 32'(fault_count), 32'(e.cnt));
                chk("clear_ack",   32'(clear_ack),   32'(e.ack));
            end
        end
    end

    initial begin
        logic [SW-1:0] s_cur;
        int            hold[NG];
        int            req_hold;
        logic          req_cur;

        rst       = 1'b1;
        sensors   = '1;
        clear_req = 1'b0;

        // Reset with all sensors active, then release and let faults qualify
        repeat (2) step(1'b1, '1, 1'b0);
        repeat (6) step(1'b0, '1, 1'b0);

        // Persistence: 3 cycles qualifies, 2 cycles does not
        step(1'b0, '0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0);
        repeat (3) step(1'b0, SW'(16'h0006), 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        repeat (2) step(1'b0, SW'(16'h0006), 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);

        // Rule sweep: every value held 4 cycles on all groups, cleared between
        for (int v = 0; v < 16; v++) begin
            s_cur = '0;
            for (int g = 0; g < NG; g++) s_cur[4*g +: 4] = 4'(v);
            repeat (4) step(1'b0, s_cur, 1'b0);
            step(1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b0);
        end

        // Clear handshake with held request while faults are latched
        repeat (5) step(1'b0, SW'(16'h0011), 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);

        // Clear collides with the qualifying edge; rule stays held afterwards
        repeat (3) step(1'b0, SW'(16'h0006), 1'b0);
        step(1'b0, SW'(16'h0006), 1'b1);
        repeat (5) step(1'b0, SW'(16'h0006), 1'b0);
        repeat (2) step(1'b0, '0, 1'b0);

        // Reset during an active clear
        step(1'b0, '1, 1'b1);
        step(1'b1, '1, 1'b1);
        step(1'b0, '1, 1'b0);

        // Randomized phase with held sensor values and request pulses
        s_cur    = '0;
        req_hold = 0;
        req_cur  = 1'b0;
        for (int g = 0; g < NG; g++) hold[g] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int g = 0; g < NG; g++) begin
                if (hold[g] == 0) begin
                    s_cur[4*g +: 4] = 4'($urandom_range(0, 15));
                    hold[g]         = int'($urandom_range(1, 6));
                end
                hold[g]--;
            end
            if (req_hold == 0) begin
                req_cur  = ($urandom_range(0, 7) == 0);
                req_hold = int'($urandom_range(1, 4));
            end
            req_hold--;
            step(($urandom_range(0, 299) == 0), s_cur, req_cur);
        end

        // Drain the scoreboard within a bounded number of edges
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_monitor.md
Name: sensor_monitor

Overview:
- Multi-group sensor fault monitor and the parametrised successor of the single 4-sensor combinational error detector.
- Each group of 4 sensors applies the fault rule error = s[0] | (s[1] & s[3]) | (s[1] & s[2]).
- A group's fault is qualified only after the rule holds for PERSIST consecutive cycles; qualified faults are latched sticky.
- Faults are cleared through a req/ack handshake. The block feeds the system status/interrupt logic.

Parameters:
- NUM_GROUPS, 4, number of 4-sensor groups (>=1).
- PERSIST, 3, consecutive cycles the rule must hold before a fault latches (>=1).
- CNT_W, 8, width of the saturating fault-event counter (>=1).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- sensors  input  4*NUM_GROUPS  group g occupies bits [4g+3:4g]; bit 4g is s[0].
- clear_req  input  1  request to clear all latched faults (level).
- clear_ack  output  1  high while a clear request is being acknowledged.
- raw_error  output  NUM_GROUPS  unqualified rule result per group, from the registered inputs.
- fault  output  NUM_GROUPS  sticky qualified fault per group.
- any_fault  output  1  OR of fault.
- fault_count  output  CNT_W  number of fault-rise events, saturating.

Behaviour:
- Reset values (rst high at an edge): sensors_q=0, all persistence counters=0, fault=0, fault_count=0, FSM=IDLE, clear_ack=0. rst overrides every other event, including a clear in progress.
- Input stage: sensors is registered into sensors_q every edge. raw_error is combinational from sensors_q, so it lags sensors by 1 cycle.
- Persistence counter (per group, width $clog2(PERSIST+1)):
  - raw_error=1: increment, saturating at PERSIST.
  - raw_error=0: reset to 0.
- Fault latch:
  - fault[g] sets at the edge where counter g transitions to PERSIST, and stays set until a clear or reset.
  - Latency: input held from before edge 0 gives fault high after edge PERSIST, i.e. PERSIST+1 cycles after input change.
  - A glitch shorter than PERSIST registered cycles never sets fault.
- fault_count:
  - +1 at any edge where at least one fault bit rises 0->1. Multiple simultaneous rises count once.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst, not by a clear.
- Clear FSM, states IDLE and ACK:
  - IDLE, clear_req=1: at that edge all fault bits and all persistence counters go to 0; next state ACK.
  - ACK: clear_ack=1; stays in ACK while clear_req=1; goes to IDLE at the first edge with clear_req=0.
  - clear_ack is registered (state-decoded), so it rises 1 cycle after the clear edge.
  - Counting and fault latching resume normally while in ACK. Holding clear_req does not re-clear; a new clear needs clear_req to drop and rise again.
- Simultaneous events:
  - A counter reaching PERSIST on the clear edge: clear wins, fault stays 0, counter = 0.
  - A fault rise on the clear edge does not increment fault_count.
- any_fault is combinational OR of fault.

Optional Feature:
- Macro: SENSOR_MONITOR_MASK_EN.
- Defined: adds input group_mask [NUM_GROUPS-1:0], sampled every edge. A masked group forces its counter to 0, its raw_error output to 0, and blocks new fault sets. An already-latched fault is held (masking does not clear it).
- Undefined: no port is added and every group is always enabled.

Decomposition:
- Package sensor_monitor_pkg:
  - GROUP_W=4 constant.
  - clear_state_t enum {IDLE, ACK}.
  - Function sensor_rule(logic [3:0]) returning the fault rule.
- Sub-module sensor_group: one group's rule, persistence counter and sticky fault. Parameter PERSIST; ports clk, rst, s_q[3:0], clear, fault_set, fault.
- The top level generates NUM_GROUPS instances and owns the input register, FSM and fault_count.

Test Plan:
- Reset: rst for 2 cycles with sensors=all ones -> fault=0, fault_count=0, clear_ack=0; then rst low and sensors held -> fault=all ones after 4 edges (PERSIST=3), fault_count=1.
- Persistence: group0 sensors=4'b0110 for 3 cycles, then 0 -> raw_error[0] pulses 3 cycles, fault[0] sets at 3rd count edge; for 2 cycles only -> fault[0] stays 0.
- Rule coverage: sweep all 16 values of one group, each held 4 cycles -> fault only for 1,3,5,6,7,9,10,11,13,14,15 (odd values or bit1 with bit2/bit3).
- Clear handshake: fault=2'b11, pulse clear_req for 3 cycles -> fault=0 at request edge, clear_ack high for 3 cycles, FSM back to IDLE one edge after clear_req drops; fault_count unchanged.
- Clear collision: group counter at 2 (PERSIST=3) with clear_req on the edge it would reach 3 -> fault stays 0; rule still held -> fault sets 3 edges later, fault_count +1.
- Saturation: CNT_W=2, generate 5 separate fault-rise events (clear between each) -> fault_count sticks at 3.
